// File: rtl/pong_game_core.sv
// pong_game_core: two-player Pong engine (ball, paddles, scores, serve/play FSM) stepped once per frame tick
module pong_game_core #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int COORD_W      = 10,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_DELAY  = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle1_y,
  output logic [COORD_W-1:0] paddle2_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         state,
  output logic               point,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAMEOVER} state_t;
  localparam int CW    = COORD_W + 1;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [COORD_W-1:0] CX  = COORD_W'((SCREEN_W - BALL_SIZE) / 2),
                                 CY  = COORD_W'((SCREEN_H - BALL_SIZE) / 2),
                                 PY0 = COORD_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [CW-1:0] K_BS   = CW'(BALL_SIZE),
                            K_SP   = CW'(BALL_SPEED),
                            K_PS   = CW'(PADDLE_SPEED),
                            K_PH   = CW'(PADDLE_H),
                            K_PMAX = CW'(SCREEN_H - PADDLE_H),
                            K_H    = CW'(SCREEN_H),
                            K_W    = CW'(SCREEN_W),
                            K_XL   = CW'(PADDLE_X_L + PADDLE_W),
                            K_PXR  = CW'(PADDLE_X_R);
  localparam logic [SCORE_W-1:0] K_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   K_LAST = CNT_W'(SERVE_DELAY - 1);

  state_t               r_state;
  logic [COORD_W-1:0]   r_bx, r_by, r_p1y, r_p2y;
  logic [SCORE_W-1:0]   r_s1, r_s2;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_dx, r_dy, r_point, r_go;

  logic [CW-1:0]        w_bx, w_by, w_p1, w_p2;
  logic                 w_ov1, w_ov2, w_hit1, w_hit2, w_pt1, w_pt2, w_ybnc, w_ndx, w_ndy;
  logic [COORD_W-1:0]   w_nx, w_ny, w_p1n, w_p2n;
  logic [SCORE_W-1:0]   w_s1n, w_s2n;

  // Everything is compared one bit wider so sums near the screen edge cannot wrap
  function automatic logic [COORD_W-1:0] pad_step(input logic [CW-1:0] y, input logic up, input logic dn);
    return (up && !dn) ? ((y >= K_PS) ? COORD_W'(y - K_PS) : '0)
         : (dn && !up) ? ((y + K_PS > K_PMAX) ? COORD_W'(K_PMAX) : COORD_W'(y + K_PS))
         : COORD_W'(y);
  endfunction

  assign w_bx  = {1'b0, r_bx};
  assign w_by  = {1'b0, r_by};
  assign w_p1  = {1'b0, r_p1y};
  assign w_p2  = {1'b0, r_p2y};
  assign w_p1n = pad_step(w_p1, p1_up, p1_down);
  assign w_p2n = pad_step(w_p2, p2_up, p2_down);

  assign w_ybnc = r_dy ? (w_by + K_BS + K_SP > K_H) : (w_by < K_SP);
  assign w_ny   = r_dy ? (w_ybnc ? COORD_W'(K_H - K_BS) : COORD_W'(w_by + K_SP))
                       : (w_ybnc ? '0 : COORD_W'(w_by - K_SP));
  assign w_ndy  = w_ybnc ? !r_dy : r_dy;

  assign w_ov1  = (w_by + K_BS > w_p1) && (w_by < w_p1 + K_PH);
  assign w_ov2  = (w_by + K_BS > w_p2) && (w_by < w_p2 + K_PH);
  assign w_hit1 = !r_dx && (w_bx >= K_XL) && (w_bx <= K_XL + K_SP) && w_ov1;
  assign w_pt2  = !r_dx && !w_hit1 && (w_bx < K_SP);
  assign w_hit2 = r_dx && (w_bx + K_BS <= K_PXR) && (w_bx + K_BS + K_SP >= K_PXR) && w_ov2;
  assign w_pt1  = r_dx && !w_hit2 && (w_bx + K_BS + K_SP > K_W);
  assign w_nx   = w_hit1 ? COORD_W'(K_XL) : w_hit2 ? COORD_W'(K_PXR - K_BS)
                : r_dx ? COORD_W'(w_bx + K_SP) : COORD_W'(w_bx - K_SP);
  assign w_ndx  = w_hit1 ? 1'b1 : w_hit2 ? 1'b0 : r_dx;
  assign w_s1n  = (r_s1 >= K_WIN) ? K_WIN : r_s1 + 1'b1;
  assign w_s2n  = (r_s2 >= K_WIN) ? K_WIN : r_s2 + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bx    <= CX;
      r_by    <= CY;
      r_p1y   <= PY0;
      r_p2y   <= PY0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_cnt   <= '0;
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
      r_point <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_point <= 1'b0;
      if (tick) begin
        if (r_state == SERVE || r_state == PLAY) begin
          r_p1y <= w_p1n;
          r_p2y <= w_p2n;
        end
        case (r_state)
          IDLE, GAMEOVER: if (start) begin
            r_state <= SERVE;
            r_go    <= 1'b0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_bx    <= CX;
            r_by    <= CY;
            r_cnt   <= '0;
            r_dx    <= (r_state == IDLE) ? 1'b1 : r_dx;
          end
          SERVE: begin
            r_bx    <= CX;
            r_by    <= CY;
            r_cnt   <= (r_cnt == K_LAST) ? '0 : r_cnt + 1'b1;
            r_state <= (r_cnt == K_LAST) ? PLAY : SERVE;
          end
          PLAY: if (w_pt1 || w_pt2) begin
            // The loser receives the next serve
            r_point <= 1'b1;
            r_bx    <= CX;
            r_by    <= CY;
            r_dx    <= w_pt1;
            r_dy    <= 1'b1;
            r_cnt   <= '0;
            r_s1    <= w_pt1 ? w_s1n : r_s1;
            r_s2    <= w_pt2 ? w_s2n : r_s2;
            r_state <= ((w_pt1 && w_s1n == K_WIN) || (w_pt2 && w_s2n == K_WIN)) ? GAMEOVER : SERVE;
            r_go    <= (w_pt1 && w_s1n == K_WIN) || (w_pt2 && w_s2n == K_WIN);
          end else begin
            r_bx <= w_nx;
            r_by <= w_ny;
            r_dx <= w_ndx;
            r_dy <= w_ndy;
          end
        endcase
      end
    end
  end

  assign ball_x    = r_bx;
  assign ball_y    = r_by;
  assign paddle1_y = r_p1y;
  assign paddle2_y = r_p2y;
  assign score1    = r_s1;
  assign score2    = r_s2;
  assign state     = r_state;
  assign point     = r_point;
  assign game_over = r_go;
endmodule
